// File: rtl/cnn_pkg.sv
// Shared CNN definitions: unflatten FSM states, element type and the default
// feature-map geometry agreed with the flattening stage.
package cnn_pkg;

  localparam int CNN_NUM_FEATURES     = 3;
  localparam int CNN_POOLED_HEIGHT    = 12;
  localparam int CNN_POOLED_WIDTH     = 12;
  localparam int CNN_DATA_WIDTH       = 8;
  localparam int CNN_FLATTENED_LENGTH = CNN_NUM_FEATURES * CNN_POOLED_HEIGHT * CNN_POOLED_WIDTH;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } unflatten_state_t;

  typedef logic signed [CNN_DATA_WIDTH-1:0] elem_t;

  // Index register width; a one-entry dimension still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unflatten_buffer_if.sv
// Element stream into the unflatten buffer (valid/ready with optional last).
interface unflatten_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/unflatten_index_counter.sv
// Nested feature/row/column counter; column runs fastest. wrap flags the final
// element of a frame, and an inc at wrap returns all indices to 0.
module unflatten_index_counter
  import cnn_pkg::*;
#(
  parameter int NUM_FEATURES  = CNN_NUM_FEATURES,
  parameter int POOLED_HEIGHT = CNN_POOLED_HEIGHT,
  parameter int POOLED_WIDTH  = CNN_POOLED_WIDTH,
  localparam int FW = idx_width(NUM_FEATURES),
  localparam int RW = idx_width(POOLED_HEIGHT),
  localparam int CW = idx_width(POOLED_WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [FW-1:0] f,
  output logic [RW-1:0] r,
  output logic [CW-1:0] c,
  output logic          wrap
);

  logic [FW-1:0] f_reg, f_next;
  logic [RW-1:0] r_reg, r_next;
  logic [CW-1:0] c_reg, c_next;
  logic          f_last, r_last, c_last;

  assign f_last = (f_reg == FW'(NUM_FEATURES - 1));
  assign r_last = (r_reg == RW'(POOLED_HEIGHT - 1));
  assign c_last = (c_reg == CW'(POOLED_WIDTH - 1));

  always_comb begin
    f_next = f_reg;
    r_next = r_reg;
    c_next = c_reg;
    if (clr) begin
      f_next = '0;
      r_next = '0;
      c_next = '0;
    end else if (inc) begin
      if (c_last) begin
        c_next = '0;
        if (r_last) begin
          r_next = '0;
          f_next = f_last ? '0 : f_reg + 1'b1;
        end else begin
          r_next = r_reg + 1'b1;
        end
      end else begin
        c_next = c_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_reg <= '0;
      r_reg <= '0;
      c_reg <= '0;
    end else begin
      f_reg <= f_next;
      r_reg <= r_next;
      c_reg <= c_next;
    end
  end

  assign f    = f_reg;
  assign r    = r_reg;
  assign c    = c_reg;
  assign wrap = f_last && r_last && c_last;

endmodule

// File: rtl/unflatten_buffer.sv
// Writes a flattened element stream into a registered [feature][row][col] map
// and holds it until acknowledged. Define UNFLATTEN_LAST_CHECK_EN to police in_last.
module unflatten_buffer
  import cnn_pkg::*;
#(
  parameter int NUM_FEATURES     = CNN_NUM_FEATURES,
  parameter int POOLED_HEIGHT    = CNN_POOLED_HEIGHT,
  parameter int POOLED_WIDTH     = CNN_POOLED_WIDTH,
  parameter int FLATTENED_LENGTH = CNN_FLATTENED_LENGTH,
  parameter int DATA_WIDTH       = CNN_DATA_WIDTH,
  localparam int COUNT_W = $clog2(FLATTENED_LENGTH + 1),
  localparam int FW      = idx_width(NUM_FEATURES),
  localparam int RW      = idx_width(POOLED_HEIGHT),
  localparam int CW      = idx_width(POOLED_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  unflatten_buffer_if.slave            s,
  output logic signed [DATA_WIDTH-1:0] fmap_out [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH],
  output logic                         fmap_valid,
  input  logic                         fmap_ack,
  output logic [COUNT_W-1:0]           elem_count,
  output logic                         frame_error
);

  generate
    if (FLATTENED_LENGTH != NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH) begin : g_len_check
      $error("unflatten_buffer: FLATTENED_LENGTH must equal NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH");
    end
  endgenerate

  unflatten_state_t   state_reg, state_next;
  logic [COUNT_W-1:0] elem_count_reg, elem_count_next;
  logic [FW-1:0]      f_idx;
  logic [RW-1:0]      r_idx;
  logic [CW-1:0]      c_idx;
  logic               wrap;
  logic               accept;
  logic               wr_en;
  logic               cnt_inc;
  logic               cnt_clr;
  logic               early_last;
  logic               last_missing;

  assign s.in_ready = (state_reg == FILL);
  assign accept     = s.in_valid && (state_reg == FILL);
  // clear outranks an accept in the same cycle, so nothing is written then.
  assign wr_en      = accept && !clear;

  unflatten_index_counter #(
    .NUM_FEATURES (NUM_FEATURES),
    .POOLED_HEIGHT(POOLED_HEIGHT),
    .POOLED_WIDTH (POOLED_WIDTH)
  ) u_index (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .f      (f_idx),
    .r      (r_idx),
    .c      (c_idx),
    .wrap   (wrap)
  );

`ifdef UNFLATTEN_LAST_CHECK_EN
  logic frame_error_reg;

  assign early_last   = s.in_last && !wrap;
  assign last_missing = !s.in_last && wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_error_reg <= 1'b0;
    end else if (clear) begin
      frame_error_reg <= 1'b0;
    end else if (accept && (early_last || last_missing)) begin
      frame_error_reg <= 1'b1;
    end
  end

  assign frame_error = frame_error_reg;
`else
  logic unused_in_last;

  assign unused_in_last = s.in_last;
  assign early_last     = 1'b0;
  assign last_missing   = 1'b0;
  assign frame_error    = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    elem_count_next = elem_count_reg;
    cnt_inc         = 1'b0;
    cnt_clr         = 1'b0;
    if (clear) begin
      state_next      = FILL;
      elem_count_next = '0;
      cnt_clr         = 1'b1;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            if (early_last) begin
              // A premature last throws the partial frame away.
              elem_count_next = '0;
              cnt_clr         = 1'b1;
            end else begin
              elem_count_next = elem_count_reg + 1'b1;
              cnt_inc         = 1'b1;
              if (wrap) begin
                state_next = FULL;
              end
            end
          end
        end
        FULL: begin
          if (fmap_ack) begin
            state_next      = FILL;
            elem_count_next = '0;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= FILL;
      elem_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      elem_count_reg <= elem_count_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int fi = 0; fi < NUM_FEATURES; fi++) begin
        for (int ri = 0; ri < POOLED_HEIGHT; ri++) begin
          for (int ci = 0; ci < POOLED_WIDTH; ci++) begin
            fmap_out[fi][ri][ci] <= '0;
          end
        end
      end
    end else if (wr_en) begin
      fmap_out[f_idx][r_idx][c_idx] <= s.in_data;
    end
  end

  assign fmap_valid = (state_reg == FULL);
  assign elem_count = elem_count_reg;

endmodule

// File: tb/tb_unflatten_buffer.sv
// Directed bench for unflatten_buffer: a flat-index reference model checked every
// cycle, plus hand-computed spot values for each scenario.
module tb_unflatten_buffer;
  import cnn_pkg::*;

  localparam int NF  = 3;
  localparam int NH  = 12;
  localparam int NW  = 12;
  localparam int LEN = NF * NH * NW;
`ifdef UNFLATTEN_LAST_CHECK_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  reset_n;
  logic  clear;
  logic  fmap_ack;
  elem_t fmap_out [NF][NH][NW];
  logic  fmap_valid;
  logic [8:0] elem_count;
  logic  frame_error;

  unflatten_buffer_if #(.DATA_WIDTH(8)) sif ();

  unflatten_buffer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .s          (sif),
    .fmap_out   (fmap_out),
    .fmap_valid (fmap_valid),
    .fmap_ack   (fmap_ack),
    .elem_count (elem_count),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: element k of a frame lands at flat index k.
  int    m_count;
  bit    m_full;
  bit    m_err;
  elem_t m_map [NF][NH][NW];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_count <= 0;
      m_full  <= 1'b0;
      m_err   <= 1'b0;
      foreach (m_map[a, b, c]) m_map[a][b][c] <= '0;
    end else if (clear) begin
      m_count <= 0;
      m_full  <= 1'b0;
      m_err   <= 1'b0;
    end else if (m_full) begin
      if (fmap_ack) begin
        m_full  <= 1'b0;
        m_count <= 0;
      end
    end else if (sif.in_valid) begin
      m_map[m_count / (NH * NW)][(m_count / NW) % NH][m_count % NW] <= sif.in_data;
      if (LAST_EN && sif.in_last && m_count < LEN - 1) begin
        m_count <= 0;
        m_err   <= 1'b1;
      end else begin
        m_count <= m_count + 1;
        if (m_count == LEN - 1) begin
          m_full <= 1'b1;
          if (LAST_EN && !sif.in_last) m_err <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int bad_idx;
      bad_idx = -1;
      chk("in_ready", int'(sif.in_ready), int'(!m_full));
      chk("fmap_valid", int'(fmap_valid), int'(m_full));
      chk("elem_count", int'(elem_count), m_count);
      chk("frame_error", int'(frame_error), int'(m_err));
      for (int k = LEN - 1; k >= 0; k--) begin
        if (fmap_out[k / (NH * NW)][(k / NW) % NH][k % NW] !== m_map[k / (NH * NW)][(k / NW) % NH][k % NW])
          bad_idx = k;
      end
      n_total++;
      if (bad_idx < 0) n_pass++;
      else $display("FAIL map: element %0d got %0d expected %0d at %0t", bad_idx,
                    fmap_out[bad_idx / (NH * NW)][(bad_idx / NW) % NH][bad_idx % NW],
                    m_map[bad_idx / (NH * NW)][(bad_idx / NW) % NH][bad_idx % NW], $time);
    end
  end

  task automatic send(input int data, input bit last);
    sif.in_valid = 1'b1;
    sif.in_data  = 8'(data);
    sif.in_last  = last;
    @(negedge clk);
  endtask

  task automatic idle();
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_frame();
    sif.in_valid = 1'b0;
    fmap_ack     = 1'b1;
    @(negedge clk);
    fmap_ack     = 1'b0;
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    clear        = 1'b0;
    fmap_ack     = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    sif.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(sif.in_ready), 1);
    chk("rst_fmap_valid", int'(fmap_valid), 0);
    chk("rst_elem_count", int'(elem_count), 0);
    chk("rst_map", int'(fmap_out[2][11][11]), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);

    // Full frame at one element per cycle.
    for (int i = 0; i < LEN; i++) begin
      if (i == LEN - 1) chk("valid_before_last", int'(fmap_valid), 0);
      send(i, i == LEN - 1);
    end
    sif.in_valid = 1'b0;
    chk("valid_after_last", int'(fmap_valid), 1);
    chk("count_full", int'(elem_count), 432);
    chk("map_1_0_0", int'(fmap_out[1][0][0]), -112);
    chk("map_2_11_11", int'(fmap_out[2][11][11]), -81);
    chk("map_0_0_5", int'(fmap_out[0][0][5]), 5);
    $display("frame 1: streamed %0d elements back to back", LEN);

    // Stall in FULL, then ack with in_valid also high.
    for (int i = 0; i < 10; i++) send(99, 1'b0);
    chk("stall_ready", int'(sif.in_ready), 0);
    chk("stall_map", int'(fmap_out[1][0][0]), -112);
    fmap_ack = 1'b1;
    @(negedge clk);
    fmap_ack = 1'b0;
    chk("ack_ready", int'(sif.in_ready), 1);
    chk("ack_valid", int'(fmap_valid), 0);
    chk("ack_count", int'(elem_count), 0);
    send(5, 1'b0);
    chk("restart_map", int'(fmap_out[0][0][0]), 5);
    chk("restart_count", int'(elem_count), 1);
    $display("stall: 10 held cycles, ack released frame");

    // Remainder of frame 2 with random gaps.
    for (int i = 1; i < LEN; i++) begin
      if ($urandom_range(0, 1) == 1) idle();
      send(i * 3, i == LEN - 1);
    end
    sif.in_valid = 1'b0;
    chk("gap_valid", int'(fmap_valid), 1);
    chk("gap_map_2_11_11", int'(fmap_out[2][11][11]), 13);
    sif.in_valid = 1'b1;
    sif.in_data  = 8'd1;
    fmap_ack     = 1'b1;
    @(negedge clk);
    fmap_ack     = 1'b0;
    sif.in_valid = 1'b0;
    chk("ack_with_valid_count", int'(elem_count), 0);
    $display("frame 2: random gaps, ack concurrent with in_valid");

    // Clear after 100 accepts, then a clean frame.
    for (int i = 0; i < 100; i++) send(i + 3, 1'b0);
    chk("pre_clear_count", int'(elem_count), 100);
    sif.in_valid = 1'b1;
    sif.in_data  = 8'd50;
    clear        = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sif.in_valid = 1'b0;
    chk("clear_count", int'(elem_count), 0);
    chk("clear_valid", int'(fmap_valid), 0);
    chk("clear_no_write", int'(fmap_out[0][8][4]), 44);
    chk("clear_retain", int'(fmap_out[0][0][0]), 3);
    for (int i = 0; i < LEN; i++) send(i + 3, i == LEN - 1);
    sif.in_valid = 1'b0;
    chk("post_clear_valid", int'(fmap_valid), 1);
    chk("post_clear_map", int'(fmap_out[0][1][0]), 15);
    ack_frame();
    $display("clear: aborted at 100, next frame complete");

    // Early last at index 200, then a frame missing its last.
    for (int i = 0; i <= 200; i++) send(i, i == 200);
    sif.in_valid = 1'b0;
    chk("early_last_err", int'(frame_error), int'(LAST_EN));
    chk("early_last_count", int'(elem_count), LAST_EN ? 0 : 201);
    n = 0;
    while (!fmap_valid && n < 1000) begin
      send(n, 1'b0);
      n++;
    end
    sif.in_valid = 1'b0;
    chk("missing_last_full", int'(fmap_valid), 1);
    chk("missing_last_err", int'(frame_error), int'(LAST_EN));
    chk("missing_last_count", int'(elem_count), 432);
    ack_frame();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("err_cleared", int'(frame_error), 0);
    $display("last check: early and missing last handled");

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 57; i++) send(i + 10, 1'b0);
    sif.in_valid = 1'b1;
    sif.in_data  = 8'd67;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_ready", int'(sif.in_ready), 1);
    chk("areset_valid", int'(fmap_valid), 0);
    chk("areset_count", int'(elem_count), 0);
    chk("areset_map", int'(fmap_out[0][0][0]), 0);
    chk("areset_err", int'(frame_error), 0);
    sif.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("async reset: outputs cleared before next edge");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
